// File: rtl/rob_multi.sv
// Parametrised reorder buffer: in-order multi-lane allocate and retire, result
// capture from forwarding buses, bypassed operand lookup and partial flush.
module rob_multi #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned DISPATCH = 4,
  parameter int unsigned NFWD     = 4,
  parameter int unsigned COMMIT   = 2,
  parameter int unsigned NREAD    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DISPATCH-1:0]               alloc_valid,
  input  logic [DISPATCH*PC_W-1:0]          alloc_pc,
  input  logic [DISPATCH-1:0]               alloc_wr,
  input  logic [DISPATCH*3-1:0]             alloc_dst,
  output logic                              alloc_ok,
  output logic [DISPATCH*IDX_W-1:0]         alloc_idx,
  input  logic [NFWD*(1+IDX_W+DATA_W)-1:0]  fwd,
  input  logic [NREAD*IDX_W-1:0]            rd_idx,
  output logic [NREAD-1:0]                  rd_ready,
  output logic [NREAD*DATA_W-1:0]           rd_value,
  output logic [COMMIT-1:0]                 cm_valid,
  output logic [COMMIT-1:0]                 cm_wr,
  output logic [COMMIT*3-1:0]               cm_dst,
  output logic [COMMIT*DATA_W-1:0]          cm_value,
  output logic [COMMIT*PC_W-1:0]            cm_pc,
  input  logic                              flush,
  input  logic [IDX_W-1:0]                  flush_idx,
  output logic [IDX_W:0]                    count,
  output logic                              full,
  output logic                              empty
);

  localparam int unsigned DST_W = 3;
  localparam int unsigned FWD_W = 1 + IDX_W + DATA_W;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned SUM_W = IDX_W + 2;

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0]  wr_q, wr_d;
  logic [DST_W-1:0]  dst_q [DEPTH];
  logic [DST_W-1:0]  dst_d [DEPTH];
  logic [PC_W-1:0]   pc_q [DEPTH];
  logic [PC_W-1:0]   pc_d [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];

  logic [NFWD-1:0]   fwd_v;
  logic [IDX_W-1:0]  fwd_i [NFWD];
  logic [DATA_W-1:0] fwd_val [NFWD];

  logic [SUM_W-1:0]  retire_cnt, n_alloc, free_slots;
  logic [IDX_W-1:0]  cidx, flush_len;
  logic              stop, flush_hit;

  // Unpack forwarding buses: {valid, idx, value} with value in the LSBs
  for (genvar gb = 0; gb < NFWD; gb++) begin : g_fwd
    assign fwd_val[gb] = fwd[gb*FWD_W +: DATA_W];
    assign fwd_i[gb]   = fwd[gb*FWD_W + DATA_W +: IDX_W];
    assign fwd_v[gb]   = fwd[gb*FWD_W + DATA_W + IDX_W];
  end

  // Operand lookup; walking buses high-to-low lets the lowest matching bus win
  always_comb begin
    rd_ready = '0;
    rd_value = '0;
    for (int p = 0; p < int'(NREAD); p++) begin
      rd_ready[p]                 = ready_q[rd_idx[p*IDX_W +: IDX_W]];
      rd_value[p*DATA_W +: DATA_W] = value_q[rd_idx[p*IDX_W +: IDX_W]];
      for (int b = int'(NFWD) - 1; b >= 0; b--) begin
        if (fwd_v[b] && (fwd_i[b] == rd_idx[p*IDX_W +: IDX_W])) begin
          rd_ready[p]                 = 1'b1;
          rd_value[p*DATA_W +: DATA_W] = fwd_val[b];
        end
      end
    end
  end

  // Commit window: contiguous ready entries from head, cut after a flushed branch
  always_comb begin
    cm_valid   = '0;
    cm_wr      = '0;
    cm_dst     = '0;
    cm_value   = '0;
    cm_pc      = '0;
    retire_cnt = '0;
    flush_hit  = 1'b0;
    stop       = 1'b0;
    cidx       = head_q;
    for (int k = 0; k < int'(COMMIT); k++) begin
      cidx = head_q + IDX_W'(k);
      if (!stop && busy_q[cidx] && ready_q[cidx]) begin
        cm_valid[k]                  = 1'b1;
        cm_wr[k]                     = wr_q[cidx];
        cm_dst[k*DST_W +: DST_W]     = dst_q[cidx];
        cm_value[k*DATA_W +: DATA_W] = value_q[cidx];
        cm_pc[k*PC_W +: PC_W]        = pc_q[cidx];
        retire_cnt                   = retire_cnt + SUM_W'(1);
        if (flush && (cidx == flush_idx)) begin
          stop      = 1'b1;
          flush_hit = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  // All-or-nothing allocation; this cycle's retirements free slots immediately
  always_comb begin
    n_alloc   = '0;
    alloc_idx = '0;
    for (int i = 0; i < int'(DISPATCH); i++) begin
      n_alloc                      = n_alloc + SUM_W'(alloc_valid[i]);
      alloc_idx[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
    end
    free_slots = SUM_W'(DEPTH) - SUM_W'(count_q) + retire_cnt;
    alloc_ok   = (n_alloc != '0) && (n_alloc <= free_slots) && !flush;
  end

  // Pointer and occupancy update
  always_comb begin
    head_d    = head_q + IDX_W'(retire_cnt);
    tail_d    = tail_q;
    count_d   = count_q - CNT_W'(retire_cnt);
    flush_len = '0;
    if (flush) begin
      tail_d    = flush_idx + IDX_W'(1);
      count_d   = flush_hit ? '0 : CNT_W'(IDX_W'(flush_idx - head_d)) + CNT_W'(1);
      flush_len = tail_q - flush_idx - IDX_W'(1);
    end else if (alloc_ok) begin
      tail_d  = tail_q + IDX_W'(n_alloc);
      count_d = count_q - CNT_W'(retire_cnt) + CNT_W'(n_alloc);
    end
  end

  // Entry update: capture, then retire/squash, then allocation overrides
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    wr_d    = wr_q;
    dst_d   = dst_q;
    pc_d    = pc_q;
    value_d = value_q;
    for (int b = int'(NFWD) - 1; b >= 0; b--) begin
      if (fwd_v[b] && busy_q[fwd_i[b]]) begin
        ready_d[fwd_i[b]] = 1'b1;
        value_d[fwd_i[b]] = fwd_val[b];
      end
    end
    for (int k = 0; k < int'(COMMIT); k++) begin
      if (cm_valid[k]) begin
        busy_d[head_q + IDX_W'(k)]  = 1'b0;
        ready_d[head_q + IDX_W'(k)] = 1'b0;
      end
    end
    if (flush) begin
      for (int e = 0; e < int'(DEPTH); e++) begin
        if (IDX_W'(IDX_W'(e) - flush_idx - IDX_W'(1)) < flush_len) begin
          busy_d[e]  = 1'b0;
          ready_d[e] = 1'b0;
        end
      end
    end
    if (alloc_ok) begin
      for (int i = 0; i < int'(DISPATCH); i++) begin
        if (alloc_valid[i]) begin
          busy_d[tail_q + IDX_W'(i)]  = 1'b1;
          ready_d[tail_q + IDX_W'(i)] = 1'b0;
          wr_d[tail_q + IDX_W'(i)]    = alloc_wr[i];
          dst_d[tail_q + IDX_W'(i)]   = alloc_dst[i*DST_W +: DST_W];
          pc_d[tail_q + IDX_W'(i)]    = alloc_pc[i*PC_W +: PC_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Payload storage is qualified by busy/ready, so it needs no reset
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    dst_q   <= dst_d;
    pc_q    <= pc_d;
    value_q <= value_d;
  end

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule
